// File: rtl/cache_pkg.sv
// Shared types for the cache request sequencer: opcodes, response status
// codes and controller states.
package cache_pkg;

    typedef enum logic [1:0] {
        OP_GET  = 2'b00,
        OP_PUT  = 2'b01,
        OP_DEL  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_MISS = 2'b01,
        ST_FULL = 2'b10,
        ST_ERR  = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITE,
        S_DELETE,
        S_RESPOND
    } ctrl_state_e;

    localparam logic [1:0] STATUS_OK   = 2'b00;
    localparam logic [1:0] STATUS_MISS = 2'b01;
    localparam logic [1:0] STATUS_FULL = 2'b10;
    localparam logic [1:0] STATUS_ERR  = 2'b11;

endpackage

// File: rtl/cache_controller_if.sv
// Command/response handshake between the protocol decoder (master) and the
// cache controller (slave).
interface cache_controller_if #(
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 64
);
    logic                   req_valid;
    logic                   req_ready;
    logic [1:0]             req_op;
    logic [KEY_WIDTH-1:0]   req_key;
    logic [VALUE_WIDTH-1:0] req_value;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [1:0]             resp_status;
    logic [VALUE_WIDTH-1:0] resp_value;

    modport master (
        output req_valid, req_op, req_key, req_value, resp_ready,
        input  req_ready, resp_valid, resp_status, resp_value
    );

    modport slave (
        input  req_valid, req_op, req_key, req_value, resp_ready,
        output req_ready, resp_valid, resp_status, resp_value
    );
endinterface

// File: rtl/cache_controller_free_slot_finder.sv
// Lowest-numbered free entry of the used vector, one-hot, plus an
// all-entries-used flag.
module free_slot_finder #(
    parameter int NUM_ENTRIES = 16
) (
    input  logic [NUM_ENTRIES-1:0] used,
    output logic [NUM_ENTRIES-1:0] free_slot,
    output logic                   full
);
    always_comb begin
        free_slot = '0;
        // Scan high to low so the lowest free index is the last one written.
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!used[i]) begin
                free_slot    = '0;
                free_slot[i] = 1'b1;
            end
        end
        full = &used;
    end
endmodule

// File: rtl/cache_controller.sv
// One-command-at-a-time sequencer in front of memory_block: lookup, then an
// optional write/delete strobe, then a held response.
module cache_controller
    import cache_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    cache_controller_if.slave      bus,
    output logic                   mem_write,
    output logic                   mem_select_by_index,
    output logic                   mem_delete,
    output logic [KEY_WIDTH-1:0]   mem_key,
    output logic [VALUE_WIDTH-1:0] mem_value,
    output logic [NUM_ENTRIES-1:0] mem_index,
    input  logic [VALUE_WIDTH-1:0] mem_value_out,
    input  logic [NUM_ENTRIES-1:0] mem_index_out,
    input  logic                   mem_hit,
    input  logic [NUM_ENTRIES-1:0] mem_used_entries,
    output logic [CNT_WIDTH-1:0]   hit_count,
    output logic [CNT_WIDTH-1:0]   miss_count
);
    ctrl_state_e            state;
    op_e                    op_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [VALUE_WIDTH-1:0] value_q;
    logic [NUM_ENTRIES-1:0] free_slot;
    logic                   full;

    free_slot_finder #(.NUM_ENTRIES(NUM_ENTRIES)) u_free (
        .used      (mem_used_entries),
        .free_slot (free_slot),
        .full      (full)
    );

    assign mem_select_by_index = 1'b0;
    assign mem_key             = key_q;
    assign mem_value           = value_q;

    // Strobes and index are flops set on entry to WRITE/DELETE, so the
    // per-cell delete reset never sees a combinational glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            op_q            <= OP_GET;
            key_q           <= '0;
            value_q         <= '0;
            mem_write       <= 1'b0;
            mem_delete      <= 1'b0;
            mem_index       <= '0;
            bus.req_ready   <= 1'b1;
            bus.resp_valid  <= 1'b0;
            bus.resp_status <= STATUS_OK;
            bus.resp_value  <= '0;
            hit_count       <= '0;
            miss_count      <= '0;
        end else begin
            mem_write  <= 1'b0;
            mem_delete <= 1'b0;
            mem_index  <= '0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q          <= op_e'(bus.req_op);
                        key_q         <= bus.req_key;
                        value_q       <= bus.req_value;
                        bus.req_ready <= 1'b0;
                        state         <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (op_q == OP_RSVD || key_q == '0) begin
                        bus.resp_status <= STATUS_ERR;
                        bus.resp_value  <= '0;
                        bus.resp_valid  <= 1'b1;
                        state           <= S_RESPOND;
                    end else if (op_q == OP_GET) begin
                        bus.resp_valid <= 1'b1;
                        state          <= S_RESPOND;
                        if (mem_hit) begin
                            bus.resp_status <= STATUS_OK;
                            bus.resp_value  <= mem_value_out;
                            if (hit_count != '1) hit_count <= hit_count + 1'b1;
                        end else begin
                            bus.resp_status <= STATUS_MISS;
                            bus.resp_value  <= '0;
                            if (miss_count != '1) miss_count <= miss_count + 1'b1;
                        end
                    end else if (op_q == OP_PUT) begin
                        if (mem_hit || !full) begin
                            mem_write <= 1'b1;
                            mem_index <= mem_hit ? mem_index_out : free_slot;
                            state     <= S_WRITE;
                        end else begin
                            bus.resp_status <= STATUS_FULL;
                            bus.resp_value  <= '0;
                            bus.resp_valid  <= 1'b1;
                            state           <= S_RESPOND;
                        end
                    end else begin
                        if (mem_hit) begin
                            mem_delete <= 1'b1;
                            mem_index  <= mem_index_out;
                            state      <= S_DELETE;
                        end else begin
                            bus.resp_status <= STATUS_MISS;
                            bus.resp_value  <= '0;
                            bus.resp_valid  <= 1'b1;
                            state           <= S_RESPOND;
                        end
                    end
                end
                S_WRITE, S_DELETE: begin
                    bus.resp_status <= STATUS_OK;
                    bus.resp_value  <= '0;
                    bus.resp_valid  <= 1'b1;
                    state           <= S_RESPOND;
                end
                S_RESPOND: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid  <= 1'b0;
                        bus.resp_status <= STATUS_OK;
                        bus.resp_value  <= '0;
                        bus.req_ready   <= 1'b1;
                        state           <= S_IDLE;
                    end
                end
                default: begin
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                    state          <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: behavioural memory_block, vector table with a response
// scoreboard, and hand-written reset/backpressure/saturation sequences.
module tb_cache_controller;
    import cache_pkg::*;

    localparam int N  = 16;
    localparam int KW = 16;
    localparam int VW = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_write, mem_select_by_index, mem_delete;
    logic [KW-1:0] mem_key;
    logic [VW-1:0] mem_value, mem_value_out;
    logic [N-1:0]  mem_index, mem_index_out, mem_used_entries;
    logic          mem_hit;
    logic [CW-1:0] hit_count, miss_count;

    cache_controller_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW)) bus ();

    cache_controller #(.NUM_ENTRIES(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .CNT_WIDTH(CW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .bus                 (bus),
        .mem_write           (mem_write),
        .mem_select_by_index (mem_select_by_index),
        .mem_delete          (mem_delete),
        .mem_key             (mem_key),
        .mem_value           (mem_value),
        .mem_index           (mem_index),
        .mem_value_out       (mem_value_out),
        .mem_index_out       (mem_index_out),
        .mem_hit             (mem_hit),
        .mem_used_entries    (mem_used_entries),
        .hit_count           (hit_count),
        .miss_count          (miss_count)
    );

    always #5 clk = ~clk;

    // Behavioural memory_block: combinational key match, clocked write/delete,
    // cleared by its rst_n (tied to ~rst).
    logic [KW-1:0] m_key [N];
    logic [VW-1:0] m_val [N];
    logic [N-1:0]  m_used;
    assign mem_used_entries = m_used;

    always_comb begin
        mem_hit       = 1'b0;
        mem_index_out = '0;
        mem_value_out = '0;
        for (int i = 0; i < N; i++) begin
            if (m_used[i] && m_key[i] == mem_key) begin
                mem_hit          = 1'b1;
                mem_index_out[i] = 1'b1;
                mem_value_out    = m_val[i];
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) m_used <= '0;
        else begin
            for (int i = 0; i < N; i++) begin
                if (mem_index[i] && mem_write) begin
                    m_key[i]  <= mem_key;
                    m_val[i]  <= mem_value;
                    m_used[i] <= 1'b1;
                end else if (mem_index[i] && mem_delete) begin
                    m_used[i] <= 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic [1:0]    op;
        logic [KW-1:0] key;
        logic [VW-1:0] value;
        logic [1:0]    st;
        logic [VW-1:0] rv;
        logic          wr;
        logic          del;
        logic [N-1:0]  idx;
    } vec_t;

    typedef struct {
        logic [1:0]    st;
        logic [VW-1:0] v;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] value,
                       input logic [1:0] st, input logic [VW-1:0] rv,
                       input logic wr, input logic del, input logic [N-1:0] idx);
        vec_t v;
        v.op = op; v.key = key; v.value = value; v.st = st; v.rv = rv;
        v.wr = wr; v.del = del; v.idx = idx;
        vecs.push_back(v);
    endtask

    // Drive one command, push its expectation, then watch strobes and pop on
    // the response. Sample k after the accept edge shows the state at edge k.
    task automatic run_vec(input vec_t v, input int hold);
        int           wr_n, del_n, lat;
        logic [N-1:0] idx_seen;
        bit           got;
        exp_t         ex;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_op     = v.op;
        bus.req_key    = v.key;
        bus.req_value  = v.value;
        bus.resp_ready = (hold == 0);
        sb.push_back('{v.st, v.rv});
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.req_ready) begin got = 1; break; end
            @(negedge clk);
        end
        chk("accept", {63'd0, got}, 64'd1);
        wr_n = 0; del_n = 0; lat = 0; idx_seen = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (mem_write)  begin wr_n++;  idx_seen = mem_index; end
            if (mem_delete) begin del_n++; idx_seen = mem_index; end
            if (bus.resp_valid) begin lat = k; break; end
        end
        chk("latency", 64'(lat), (v.wr || v.del) ? 64'd3 : 64'd2);
        chk("write_pulses", 64'(wr_n), 64'(v.wr));
        chk("delete_pulses", 64'(del_n), 64'(v.del));
        chk("strobe_index", 64'(idx_seen), 64'(v.idx));
        if (lat != 0 && sb.size() > 0) begin
            ex = sb.pop_front();
            for (int h = 0; h < hold; h++) begin
                chk("hold_valid", 64'(bus.resp_valid), 64'd1);
                chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
                chk("hold_status", 64'(bus.resp_status), 64'(ex.st));
                @(negedge clk);
            end
            chk("resp_status", 64'(bus.resp_status), 64'(ex.st));
            chk("resp_value", bus.resp_value, ex.v);
            bus.resp_ready = 1'b1;
            @(negedge clk);
            chk("post_resp_valid", 64'(bus.resp_valid), 64'd0);
            chk("post_resp_req_ready", 64'(bus.req_ready), 64'd1);
        end else begin
            sb.delete();
        end
    endtask

    initial begin
        vec_t v;
        logic [N-1:0] one_hot;

        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_key = '0;
        bus.req_value = '0;   bus.resp_ready = 1'b1;

        // Table: PUT/GET basics, fill to 16, FULL, overwrite, delete, reuse, ERR.
        add(OP_PUT, 16'h0001, 64'h11, STATUS_OK,   64'h0,  1, 0, 16'h0001);
        add(OP_GET, 16'h0001, 64'h0,  STATUS_OK,   64'h11, 0, 0, 16'h0000);
        add(OP_GET, 16'h0002, 64'h0,  STATUS_MISS, 64'h0,  0, 0, 16'h0000);
        for (int k = 2; k <= 16; k++) begin
            one_hot = '0;
            one_hot[k-1] = 1'b1;
            add(OP_PUT, 16'(k), 64'h100 + 64'(k), STATUS_OK, 64'h0, 1, 0, one_hot);
        end
        add(OP_PUT, 16'h0020, 64'h20, STATUS_FULL, 64'h0,  0, 0, 16'h0000);
        add(OP_PUT, 16'h0005, 64'hAA, STATUS_OK,   64'h0,  1, 0, 16'h0010);
        add(OP_GET, 16'h0005, 64'h0,  STATUS_OK,   64'hAA, 0, 0, 16'h0000);
        add(OP_DEL, 16'h0003, 64'h0,  STATUS_OK,   64'h0,  0, 1, 16'h0004);
        add(OP_GET, 16'h0003, 64'h0,  STATUS_MISS, 64'h0,  0, 0, 16'h0000);
        add(OP_PUT, 16'h0030, 64'h33, STATUS_OK,   64'h0,  1, 0, 16'h0004);
        add(OP_DEL, 16'h0099, 64'h0,  STATUS_MISS, 64'h0,  0, 0, 16'h0000);
        add(OP_PUT, 16'h0000, 64'h55, STATUS_ERR,  64'h0,  0, 0, 16'h0000);
        add(OP_GET, 16'h0030, 64'h0,  STATUS_OK,   64'h33, 0, 0, 16'h0000);

        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_status", 64'(bus.resp_status), 64'd0);
        chk("rst_resp_value", bus.resp_value, 64'd0);
        chk("rst_mem_ctrl", {61'd0, mem_write, mem_delete, mem_select_by_index}, 64'd0);
        chk("rst_mem_bus", {32'd0, mem_key, mem_index}, 64'd0);
        chk("rst_mem_value", mem_value, 64'd0);
        chk("rst_counters", {56'd0, hit_count, miss_count}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], 0);
        chk("hit_count", 64'(hit_count), 64'd3);
        chk("miss_count", 64'(miss_count), 64'd2);

        // Reserved opcode with the response held off for five cycles.
        v.op = OP_RSVD; v.key = 16'h0007; v.value = 64'h0; v.st = STATUS_ERR;
        v.rv = 64'h0; v.wr = 0; v.del = 0; v.idx = '0;
        run_vec(v, 5);

        // Hit counter saturation (4-bit counter here): 3 + 11 = 14, then +3 caps at 15.
        v.op = OP_GET; v.key = 16'h0001; v.st = STATUS_OK; v.rv = 64'h11;
        for (int i = 0; i < 11; i++) run_vec(v, 0);
        chk("hit_count_14", 64'(hit_count), 64'd14);
        for (int i = 0; i < 3; i++) run_vec(v, 0);
        chk("hit_count_sat", 64'(hit_count), 64'd15);
        chk("miss_count_gets_only", 64'(miss_count), 64'd2);

        // Reset asserted while the controller sits in WRITE.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = OP_PUT; bus.req_key = 16'h0005;
        bus.req_value = 64'hBB; bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("write_state_strobe", 64'(mem_write), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_kills_write", 64'(mem_write), 64'd0);
        chk("rst_mid_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_mid_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_mid_counters", {56'd0, hit_count, miss_count}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_write_after_rst", {62'd0, mem_write, mem_delete}, 64'd0);
            chk("idle_after_rst", 64'(bus.resp_valid), 64'd0);
        end
        v.op = OP_GET; v.key = 16'h0005; v.st = STATUS_MISS; v.rv = 64'h0;
        run_vec(v, 0);
        chk("miss_after_rst", 64'(miss_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
